// File: rtl/pp_stream_buffer_pkg.sv
// rtl/pp_stream_buffer_pkg.sv - shared types and helpers for the ping-pong stream buffer
//
// Purpose: default WiMAX block size, bank selector type and the block
// length clamp used when a new write block starts.
package pp_stream_pkg;

  localparam int WIMAX_BLK_DEFAULT = 192;

  typedef logic bank_sel_t;

  // Zero or oversize lengths fall back to a full bank.
  function automatic int clamp_len(input int raw, input int depth);
    return ((raw == 0) || (raw > depth)) ? depth : raw;
  endfunction

endpackage

// File: rtl/pp_stream_buffer_if.sv
// rtl/pp_stream_buffer_if.sv - producer/consumer bus of the ping-pong stream buffer
//
// Purpose: bundles the write side (blk_len, wr_valid, wr_addr, wr_data,
// wr_ready) and read side (rd_en, rd_addr, rd_done, rd_avail, rd_len,
// rd_data, rd_data_valid) plus err.
// master: producer/consumer side; slave: the buffer.
interface pp_stream_buffer_if #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 9
);
  logic [LEN_W-1:0]  blk_len;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              rd_avail;
  logic [LEN_W-1:0]  rd_len;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              err;

  modport master (
    output blk_len, wr_valid, wr_addr, wr_data, rd_en, rd_addr, rd_done,
    input  wr_ready, rd_avail, rd_len, rd_data, rd_data_valid, err
  );

  modport slave (
    input  blk_len, wr_valid, wr_addr, wr_data, rd_en, rd_addr, rd_done,
    output wr_ready, rd_avail, rd_len, rd_data, rd_data_valid, err
  );
endinterface

// File: rtl/pp_stream_buffer_bank_ram.sv
// rtl/pp_stream_buffer_bank_ram.sv - one bank of the ping-pong buffer
//
// Purpose: simple dual-port RAM, DATA_W x DEPTH, with a registered read port.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata write
// port, re/raddr read request, rdata registered read data (holds when !re).
module pp_bank_ram #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 192,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pp_stream_buffer.sv
// rtl/pp_stream_buffer.sv - double-bank block buffer between producer and consumer
//
// Purpose: producer fills one bank (any address order) while the consumer
// reads the other; a bank commits when the latched block length of writes
// has been accepted and is handed back by rd_done.
// Ports: clk, resetN (async active-low), bus (pp_stream_buffer_if.slave).
module pp_stream_buffer
  import pp_stream_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = WIMAX_BLK_DEFAULT,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 9
) (
  input  logic                clk,
  input  logic                resetN,
  pp_stream_buffer_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        full;
  logic [LEN_W-1:0]  bank_len [2];
  bank_sel_t         wr_bank, rd_bank, rd_sel_q;
  logic [LEN_W-1:0]  wr_cnt, len_lat, len_eff;
  logic              rd_data_valid_q, err_q;
  logic              wr_ready, rd_avail;
  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_fire, commit, release_bank;
  logic [DATA_W-1:0] bank_rdata [2];

  assign wr_ready = !full[wr_bank];
  assign rd_avail = full[rd_bank];

  assign wr_in_range = ({1'b0, bus.wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in_range = ({1'b0, bus.rd_addr} < (ADDR_W+1)'(DEPTH));

  assign wr_acc       = bus.wr_valid && wr_ready && wr_in_range;
  assign rd_fire      = bus.rd_en && rd_avail && rd_in_range;
  assign release_bank = bus.rd_done && rd_avail;

  // blk_len only matters on the first write of a block; afterwards the
  // latched copy is the length in effect.
  assign len_eff = (wr_cnt == '0) ? LEN_W'(clamp_len(int'(bus.blk_len), DEPTH)) : len_lat;
  assign commit  = wr_acc && ((wr_cnt + LEN_W'(1)) == len_eff);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full            <= '0;
      bank_len[0]     <= '0;
      bank_len[1]     <= '0;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      rd_sel_q        <= 1'b0;
      wr_cnt          <= '0;
      len_lat         <= '0;
      rd_data_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      rd_data_valid_q <= rd_fire;
      err_q <= (bus.wr_valid && (!wr_ready || !wr_in_range)) ||
               (bus.rd_en && !rd_in_range);
      if (rd_fire) rd_sel_q <= rd_bank;

      if (wr_acc) begin
        if (wr_cnt == '0) len_lat <= len_eff;
        if (commit) begin
          full[wr_bank]     <= 1'b1;
          bank_len[wr_bank] <= len_eff;
          wr_bank           <= ~wr_bank;
          wr_cnt            <= '0;
        end else begin
          wr_cnt <= wr_cnt + LEN_W'(1);
        end
      end

      // Never the same bank as a commit: the write bank is not full.
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
      .clk   (clk),
      .rst_n (resetN),
      .we    (wr_acc && (wr_bank == bank_sel_t'(b))),
      .waddr (bus.wr_addr[IDX_W-1:0]),
      .wdata (bus.wr_data),
      .re    (rd_fire && (rd_bank == bank_sel_t'(b))),
      .raddr (bus.rd_addr[IDX_W-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  // Only the bank that served the last read updates its register, so the
  // selected output holds its value between reads.
  assign bus.rd_data       = bank_rdata[rd_sel_q];
  assign bus.rd_data_valid = rd_data_valid_q;
  assign bus.err           = err_q;
  assign bus.wr_ready      = wr_ready;
  assign bus.rd_avail      = rd_avail;
  assign bus.rd_len        = rd_avail ? bank_len[rd_bank] : '0;

endmodule

// File: tb/tb_pp_stream_buffer.sv
// tb/tb_pp_stream_buffer.sv - scoreboard bench for pp_stream_buffer
module tb_pp_stream_buffer;
  localparam int DATA_W = 1;
  localparam int DEPTH  = 192;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 9;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  pp_stream_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  pp_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Reference: committed blocks form a FIFO of at most two; one partial block.
  typedef struct {
    int                len;
    logic [DATA_W-1:0] d [DEPTH];
    bit                w [DEPTH];
  } blk_t;
  typedef struct {
    logic [DATA_W-1:0] d;
    bit                care;
  } exp_t;

  blk_t blk_q[$];
  blk_t cur;
  int   cur_cnt;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   perm [DEPTH];

  function automatic int ref_clamp(int v);
    return (v == 0 || v > DEPTH) ? DEPTH : v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shuffle(int n);
    int j, t;
    for (int i = 0; i < n; i++) perm[i] = i;
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic step(bit wv, int wa, logic [DATA_W-1:0] wd, int bl,
                      bit re, int ra, bit rdn, string tag);
    int  n;
    bit  m_wr_ready, m_avail, exp_err, do_rel, do_commit;
    exp_t e;
    bus.wr_valid = wv; bus.wr_addr = ADDR_W'(wa); bus.wr_data = wd;
    bus.blk_len = LEN_W'(bl); bus.rd_en = re; bus.rd_addr = ADDR_W'(ra);
    bus.rd_done = rdn;
    n = blk_q.size();
    m_wr_ready = (n < 2);
    m_avail = (n > 0);
    exp_err = (wv && (!m_wr_ready || wa >= DEPTH)) || (re && ra >= DEPTH);
    if (re && m_avail && ra < DEPTH) begin
      e.d = blk_q[0].d[ra];
      e.care = blk_q[0].w[ra];
      exp_q.push_back(e);
    end
    do_rel = rdn && m_avail;
    do_commit = 1'b0;
    if (wv && m_wr_ready && wa < DEPTH) begin
      if (cur_cnt == 0) begin
        cur.len = ref_clamp(bl);
        foreach (cur.w[i]) cur.w[i] = 1'b0;
      end
      cur.d[wa] = wd;
      cur.w[wa] = 1'b1;
      cur_cnt++;
      if (cur_cnt == cur.len) begin
        do_commit = 1'b1;
        cur_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    if (do_rel) blk_q.delete(0);
    if (do_commit) blk_q.push_back(cur);
    chk({tag, " wr_ready"}, 64'(bus.wr_ready), 64'(blk_q.size() < 2));
    chk({tag, " rd_avail"}, 64'(bus.rd_avail), 64'(blk_q.size() > 0));
    chk({tag, " rd_len"}, 64'(bus.rd_len), 64'((blk_q.size() > 0) ? blk_q[0].len : 0));
    chk({tag, " err"}, 64'(bus.err), 64'(exp_err));
  endtask

  task automatic idle(string tag);
    step(0, 0, '0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset(string tag);
    resetN = 1'b0;
    bus.wr_valid = 0; bus.rd_en = 0; bus.rd_done = 0;
    #2;
    chk({tag, " wr_ready"}, 64'(bus.wr_ready), 64'd1);
    chk({tag, " rd_avail"}, 64'(bus.rd_avail), 64'd0);
    chk({tag, " rd_len"}, 64'(bus.rd_len), 64'd0);
    chk({tag, " rd_data_valid"}, 64'(bus.rd_data_valid), 64'd0);
    chk({tag, " err"}, 64'(bus.err), 64'd0);
    chk({tag, " rd_data"}, 64'(bus.rd_data), 64'd0);
    blk_q.delete();
    exp_q.delete();
    cur_cnt = 0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  // Write a whole block: addresses in perm order, blk_len only meaningful first.
  task automatic write_block(int bl, int n, string tag);
    for (int i = 0; i < n; i++)
      step(1, perm[i], DATA_W'($urandom), (i == 0) ? bl : $urandom_range(1, 20),
           0, 0, 0, tag);
  endtask

  task automatic read_release(int n, string tag);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 1, i, (i == n - 1), tag);
  endtask

  // Monitor: pops one expectation per presented read result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (resetN === 1'b1 && bus.rd_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got rd_data_valid=1 expected no pending read");
        end else begin
          e = exp_q.pop_front();
          if (e.care) chk("rd_data", 64'(bus.rd_data), 64'(e.d));
        end
      end
    end
  end

  initial begin : stim
    logic [191:0] vec;
    int bl, wa, ra;
    vec = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    cur_cnt = 0;
    bus.blk_len = '0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.rd_done = 0;
    resetN = 1'b1;
    #1;
    do_reset("reset");
    idle("idle");

    // Known 192-bit vector, in-order addresses.
    for (int i = 0; i < DEPTH; i++) step(1, i, vec[i], 192, 0, 0, 0, "vec_wr");
    chk("vec rd_len", 64'(bus.rd_len), 64'd192);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, '0, 0, 1, i, (i == DEPTH - 1), "vec_rd");
      chk("vec rd_valid_lat1", 64'(bus.rd_data_valid), 64'd1);
      chk("vec rd_data", 64'(bus.rd_data), 64'(vec[i]));
    end

    // Streaming: release of the read bank coincides with the write commit.
    shuffle(DEPTH);
    write_block(192, DEPTH, "stream_first");
    for (int k = 0; k < 10; k++) begin
      shuffle(DEPTH);
      for (int j = 0; j < DEPTH; j++) begin
        step(1, perm[j], DATA_W'($urandom), 192, 1, j, (j == DEPTH - 1), "stream");
        chk("stream wr_ready_high", 64'(bus.wr_ready), 64'd1);
      end
    end
    read_release(DEPTH, "stream_drain");

    // Both banks full, then a dropped write.
    shuffle(5);  write_block(5, 5, "fill_a");
    shuffle(7);  write_block(7, 7, "fill_b");
    step(1, 3, 1'b1, 5, 0, 0, 0, "drop");
    chk("drop err", 64'(bus.err), 64'd1);
    idle("drop_after");
    chk("drop err_one_cycle", 64'(bus.err), 64'd0);
    read_release(5, "fill_rel_a");
    chk("fill wr_ready_after_rel", 64'(bus.wr_ready), 64'd1);
    read_release(7, "fill_rel_b");

    // Clamp of 0 and 500.
    shuffle(DEPTH); write_block(0, DEPTH, "clamp0");
    chk("clamp0 rd_len", 64'(bus.rd_len), 64'd192);
    read_release(DEPTH, "clamp0_rd");
    shuffle(DEPTH); write_block(500, DEPTH, "clamp500");
    chk("clamp500 rd_len", 64'(bus.rd_len), 64'd192);
    read_release(DEPTH, "clamp500_rd");

    // Length 12, reversed addresses, with out-of-range accesses mixed in.
    for (int i = 0; i < 12; i++) begin
      step(1, 11 - i, DATA_W'($urandom), (i == 0) ? 12 : 3, 0, 0, 0, "len12");
      if (i == 5) begin
        step(1, 200, 1'b1, 12, 0, 0, 0, "oor_wr");
        chk("oor_wr err", 64'(bus.err), 64'd1);
        step(0, 0, '0, 12, 1, 300, 0, "oor_rd");
        chk("oor_rd err", 64'(bus.err), 64'd1);
      end
    end
    chk("len12 rd_len", 64'(bus.rd_len), 64'd12);
    read_release(12, "len12_rd");

    // Random traffic: short blocks, duplicate and out-of-range addresses.
    for (int c = 0; c < 3000; c++) begin
      bl = $urandom_range(1, 20);
      wa = ($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 511) : $urandom_range(0, 23);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 511) : $urandom_range(0, 23);
      step($urandom_range(0, 9) < 7, wa, DATA_W'($urandom), bl,
           $urandom_range(0, 1), ra, $urandom_range(0, 9) == 0, "rand");
    end

    // Reset in the middle of a block.
    do_reset("pre_mid");
    shuffle(DEPTH);
    write_block(192, 100, "mid_wr");
    do_reset("mid_reset");
    shuffle(DEPTH);
    write_block(192, DEPTH, "post_reset");
    chk("post_reset rd_len", 64'(bus.rd_len), 64'd192);
    read_release(DEPTH, "post_reset_rd");

    idle("tail");
    idle("tail");
    chk("pending_reads", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
